// File: rtl/rom_arb_pkg.sv
// Shared definitions for the instruction-ROM port arbiter: owner encoding
// and default geometry of the shared synchronous-read ROM.
package rom_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int WAIT_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } owner_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive cycles the fetch port was denied; flags
// starvation once the count reaches the limit while the fetch is still pending.
module starve_counter
  import rom_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic rawclk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic starve
);

  localparam logic [WAIT_CNT_WIDTH-1:0] LIMIT = WAIT_CNT_WIDTH'(MAX_WAIT);

  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;

  always_ff @(posedge rawclk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!req || gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign starve = req && (wait_cnt == LIMIT);

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one single-cycle-latency instruction ROM between the fetch port and
// the data-side read port; one grant per cycle, responses in grant order.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  rawclk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  // Handshake: a port's gnt is high only in a cycle where its req is high;
  // the read it starts returns as a one-cycle rvalid two cycles later, with
  // rdata held until that port's next rvalid.

  logic            starve;
  logic            if_win;
  logic            ld_win;
  owner_t          owner;
  owner_t          owner_next;
  logic [ADDR_WIDTH-1:0] last_addr;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .rawclk (rawclk),
    .rst    (rst),
    .req    (if_req),
    .gnt    (if_gnt),
    .starve (starve)
  );

  always_comb begin
    if_win     = 1'b0;
    ld_win     = 1'b0;
    owner_next = OWN_NONE;
    if (!rst) begin
      if (ld_req && !starve) begin
        ld_win     = 1'b1;
        owner_next = OWN_LD;
      end else if (if_req) begin
        if_win     = 1'b1;
        owner_next = OWN_IF;
      end
    end
  end

  assign if_gnt = if_win;
  assign ld_gnt = ld_win;

  // Idle cycles replay the last granted address so the ROM input stays quiet.
  always_comb begin
    rom_addr = last_addr;
    if (if_win) begin
      rom_addr = if_addr;
    end else if (ld_win) begin
      rom_addr = ld_addr;
    end
  end

  always_ff @(posedge rawclk) begin
    if (rst) begin
      owner     <= OWN_NONE;
      last_addr <= '0;
    end else begin
      owner <= owner_next;
      if (if_win || ld_win) begin
        last_addr <= rom_addr;
      end
    end
  end

  // Reset drops any read still in flight: owner is cleared and no rvalid follows.
  always_ff @(posedge rawclk) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
      if_rdata  <= '0;
      ld_rdata  <= '0;
    end else begin
      if_rvalid <= (owner == OWN_IF);
      ld_rvalid <= (owner == OWN_LD);
      if (owner == OWN_IF) begin
        if_rdata <= rom_data;
      end
      if (owner == OWN_LD) begin
        ld_rdata <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed table-driven bench for rom_port_arbiter with a behavioural ROM
// holding 0x1000_0000 + address at every word.
module tb_rom_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          rawclk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  int checks   = 0;
  int failures = 0;

  rom_port_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_WAIT   (4)
  ) dut (
    .rawclk    (rawclk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_gnt    (ld_gnt),
    .ld_rvalid (ld_rvalid),
    .ld_rdata  (ld_rdata),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  // clock / reset
  initial rawclk = 1'b0;
  always #5 rawclk = ~rawclk;

  // synchronous-read ROM model
  always_ff @(posedge rawclk) begin
    rom_data <= 32'h1000_0000 + {22'd0, rom_addr};
  end

  typedef struct {
    logic          ifr;
    logic [AW-1:0] ifa;
    logic          ldr;
    logic [AW-1:0] lda;
    logic          e_ig;
    logic          e_lg;
    logic [AW-1:0] e_ra;
    logic          e_iv;
    logic [DW-1:0] e_id;
    logic          e_lv;
    logic [DW-1:0] e_ld;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ifr, input int ifa, input logic ldr, input int lda,
                     input logic e_ig, input logic e_lg, input int e_ra,
                     input logic e_iv, input logic [DW-1:0] e_id,
                     input logic e_lv, input logic [DW-1:0] e_ld);
    vec_t v;
    v.ifr = ifr; v.ifa = AW'(ifa); v.ldr = ldr; v.lda = AW'(lda);
    v.e_ig = e_ig; v.e_lg = e_lg; v.e_ra = AW'(e_ra);
    v.e_iv = e_iv; v.e_id = e_id; v.e_lv = e_lv; v.e_ld = e_ld;
    vecs.push_back(v);
  endtask

  // driver: apply at negedge, sample 1 ns later (well away from posedge)
  task automatic drive(input logic r, input logic ifr, input logic [AW-1:0] ifa,
                       input logic ldr, input logic [AW-1:0] lda);
    @(negedge rawclk);
    rst = r; if_req = ifr; if_addr = ifa; ld_req = ldr; ld_addr = lda;
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = '0; ld_req = 1'b1; ld_addr = '0;

    // gnt forced low while in reset even with both requesting
    drive(1'b1, 1'b1, 10'd3, 1'b1, 10'd4);
    drive(1'b1, 1'b1, 10'd3, 1'b1, 10'd4);
    check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);

    //   ifr ifa   ldr lda   ig lg ra     iv id            lv ld
    // idle after reset
    add(0, 0,    0, 0,    0, 0, 0,     0, 32'h0,          0, 32'h0);
    // fetch 5,6,7 back to back
    add(1, 5,    0, 0,    1, 0, 5,     0, 32'h0,          0, 32'h0);
    add(1, 6,    0, 0,    1, 0, 6,     0, 32'h0,          0, 32'h0);
    add(1, 7,    0, 0,    1, 0, 7,     1, 32'h1000_0005,  0, 32'h0);
    add(0, 0,    0, 0,    0, 0, 7,     1, 32'h1000_0006,  0, 32'h0);
    add(0, 0,    0, 0,    0, 0, 7,     1, 32'h1000_0007,  0, 32'h0);
    add(0, 0,    0, 0,    0, 0, 7,     0, 32'h1000_0007,  0, 32'h0);
    // alternating owners IF(3) LD(9) IF(4)
    add(1, 3,    0, 0,    1, 0, 3,     0, 32'h1000_0007,  0, 32'h0);
    add(0, 0,    1, 9,    0, 1, 9,     0, 32'h1000_0007,  0, 32'h0);
    add(1, 4,    0, 0,    1, 0, 4,     1, 32'h1000_0003,  0, 32'h0);
    add(0, 0,    0, 0,    0, 0, 4,     0, 32'h1000_0003,  1, 32'h1000_0009);
    add(0, 0,    0, 0,    0, 0, 4,     1, 32'h1000_0004,  0, 32'h1000_0009);
    add(0, 0,    0, 0,    0, 0, 4,     0, 32'h1000_0004,  0, 32'h1000_0009);
    // both requesting: ld x4, fetch force-granted, ld again
    add(1, 32,   1, 48,   0, 1, 48,    0, 32'h1000_0004,  0, 32'h1000_0009);
    add(1, 32,   1, 48,   0, 1, 48,    0, 32'h1000_0004,  0, 32'h1000_0009);
    add(1, 32,   1, 48,   0, 1, 48,    0, 32'h1000_0004,  1, 32'h1000_0030);
    add(1, 32,   1, 48,   0, 1, 48,    0, 32'h1000_0004,  1, 32'h1000_0030);
    add(1, 32,   1, 48,   1, 0, 32,    0, 32'h1000_0004,  1, 32'h1000_0030);
    add(1, 32,   1, 48,   0, 1, 48,    0, 32'h1000_0004,  1, 32'h1000_0030);
    add(0, 0,    0, 0,    0, 0, 48,    1, 32'h1000_0020,  0, 32'h1000_0030);
    add(0, 0,    0, 0,    0, 0, 48,    0, 32'h1000_0020,  1, 32'h1000_0030);
    // address range ends 1023 then 0
    add(1, 1023, 0, 0,    1, 0, 1023,  0, 32'h1000_0020,  0, 32'h1000_0030);
    add(1, 0,    0, 0,    1, 0, 0,     0, 32'h1000_0020,  0, 32'h1000_0030);
    add(0, 0,    0, 0,    0, 0, 0,     1, 32'h1000_03FF,  0, 32'h1000_0030);
    add(0, 0,    0, 0,    0, 0, 0,     1, 32'h1000_0000,  0, 32'h1000_0030);
    add(0, 0,    0, 0,    0, 0, 0,     0, 32'h1000_0000,  0, 32'h1000_0030);

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].ifr, vecs[i].ifa, vecs[i].ldr, vecs[i].lda);
      check($sformatf("v%0d_if_gnt", i),    {31'd0, if_gnt},    {31'd0, vecs[i].e_ig});
      check($sformatf("v%0d_ld_gnt", i),    {31'd0, ld_gnt},    {31'd0, vecs[i].e_lg});
      check($sformatf("v%0d_rom_addr", i),  {22'd0, rom_addr},  {22'd0, vecs[i].e_ra});
      check($sformatf("v%0d_if_rvalid", i), {31'd0, if_rvalid}, {31'd0, vecs[i].e_iv});
      check($sformatf("v%0d_if_rdata", i),  if_rdata,           vecs[i].e_id);
      check($sformatf("v%0d_ld_rvalid", i), {31'd0, ld_rvalid}, {31'd0, vecs[i].e_lv});
      check($sformatf("v%0d_ld_rdata", i),  ld_rdata,           vecs[i].e_ld);
    end

    // reset lands the cycle after an LD grant of address 2
    drive(1'b0, 1'b0, 10'd0, 1'b1, 10'd2);
    check("inflight_ld_gnt", {31'd0, ld_gnt}, 32'd1);
    check("inflight_rom_addr", {22'd0, rom_addr}, 32'd2);
    drive(1'b1, 1'b0, 10'd0, 1'b1, 10'd5);
    check("inflight_rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
      check($sformatf("post_rst%0d_ld_rvalid", k), {31'd0, ld_rvalid}, 32'd0);
      check($sformatf("post_rst%0d_ld_rdata", k),  ld_rdata, 32'd0);
      check($sformatf("post_rst%0d_if_rvalid", k), {31'd0, if_rvalid}, 32'd0);
      check($sformatf("post_rst%0d_if_rdata", k),  if_rdata, 32'd0);
      check($sformatf("post_rst%0d_rom_addr", k),  {22'd0, rom_addr}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // safety bound on total run time
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
